instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Packs decoded instruction fields plus a 32-bit immediate back into a 32-bit RV32I instruction word.
- Inverse of the immediate-generation path.
- Used by the bootloader/self-test path to build programs into instruction memory.
- Valid/ready input, small output FIFO, per-word write address and sticky error flag.

Parameters:
DEPTH, 2, output FIFO entries (power of 2, >=2)
ADDR_W, 10, width of word write address
BASE_ADDR, 0, word address of first encoded instruction after reset/clear

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept bundle
opcode  input  7  instruction[6:0]
rd  input  5  destination register
rs1  input  5  source 1
rs2  input  5  source 2
funct3  input  3  funct3
funct7  input  7  funct7 (R, shift-immediate)
imm  input  32  immediate value, architectural (unshifted) form
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_instr  output  32  encoded word at head
out_addr  output  ADDR_W  word address paired with head
addr_clr  input  1  sync: restart address counter at BASE_ADDR
err_clr  input  1  sync: clear err_sticky
err_sticky  output  1  an unsupported/invalid bundle was pushed

Behaviour:
- Reset (rst_n low, async): FIFO emptied, out_valid=0, out_instr=0, out_addr=BASE_ADDR, address counter=BASE_ADDR, err_sticky=0. Reset asserted mid-operation discards all queued words.
- in_ready = !full. No pass-through when full, even if out_ready=1 in the same cycle.
- Push on in_valid&&in_ready: the bundle is encoded combinationally, then written with the current address counter. The counter then increments by 1 and wraps modulo 2^ADDR_W.
- Pop on out_valid&&out_ready.
- Latency: a bundle accepted at edge N is at the head from edge N if the FIFO was empty.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged. Order is strict FIFO.
- out_instr/out_addr hold while out_valid&&!out_ready. Their value when out_valid=0 is don't-care; the bench checks them only when valid.
- addr_clr alone: counter=BASE_ADDR.
- addr_clr with a push in the same cycle: pushed word takes BASE_ADDR and counter becomes BASE_ADDR+1.
- Queued entries are not relabelled by addr_clr.
- Encoding by opcode:
  - 0110111 LUI / 0010111 AUIPC: {imm[31:12],rd,opcode}
  - 1101111 JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - 1100111 JALR / 0000011 load: {imm[11:0],rs1,funct3,rd,opcode}
  - 0010011 ALU-imm:
    - funct3 = 001 or 101: {funct7,imm[4:0],rs1,funct3,rd,opcode}
    - otherwise: {imm[11:0],rs1,funct3,rd,opcode}
  - 0100011 store: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - 1100011 branch: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - 0110011 R-type: {funct7,rs2,rs1,funct3,rd,opcode}
  - Any other opcode: encodes 32'h00000013 (NOP) and flags error.
- Discarded imm bits (e.g. JAL/branch bit 0, LUI low 12) are ignored unless the optional feature is enabled.
- err_sticky: set on any push that flags an error. err_clr clears it. If set and clear occur in the same cycle, set wins.

Optional Feature:
- Macro: INSTR_ENCODER_RANGE_CHECK_EN.
- Enabled: a push also flags an error when imm does not fit the field:
  - I/S/JALR: signed 12-bit. Loads with funct3[2]=1 use unsigned 12-bit.
  - Branch: signed 13-bit and even. funct3[2:1]=11 uses unsigned 13-bit.
  - JAL: signed 21-bit and even.
  - Shift-imm: imm[31:5]=0.
  - LUI/AUIPC: imm[11:0]=0.
- The word is still encoded by truncation and still pushed.
- Disabled: only unknown opcodes set err_sticky.

Test Plan:
- addi x1,x0,5 (opcode 0010011, rd=1, imm=5) after reset, out_ready=1 -> out_instr=32'h00500093, out_addr=0, next push gets out_addr=1.
- sw x2,8(x1) (0100011, funct3=010, rs1=1, rs2=2, imm=8) -> 32'h0020A423.
- beq x0,x0,-4 (1100011, funct3=000, imm=32'hFFFFFFFC) -> 32'hFE000EE3.
- jal x1,2048 (1101111, rd=1, imm=32'h800) -> 32'h001000EF.
- out_ready=0, DEPTH=2, push 3 bundles -> in_ready=0 after 2nd. Then out_ready=1 -> words pop in order with addrs 0,1, third accepted only after a pop.
- Pulse rst_n low with FIFO full -> out_valid=0 immediately, next push addr=0.
- addi imm=2048 -> out_instr=32'h80000093. err_sticky=1 with the macro, 0 without. Opcode 7'h7F -> 32'h00000013 and err_sticky=1. err_clr -> 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields plus an architectural immediate into an instruction word and queues
// it with a word write address. Define INSTR_ENCODER_RANGE_CHECK_EN to flag out-of-range immediates.
module instr_encoder #(
  parameter int unsigned       DEPTH     = 2,
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              addr_clr,
  input  logic              err_clr,
  output logic              err_sticky
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpAluImm = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpAluReg = 7'b0110011;

  logic [31:0] enc_instr;
  logic        bad_opcode;
  logic        range_err;
  logic        enc_err;
  logic        is_shift;

  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    enc_instr  = 32'h0000_0013;
    bad_opcode = 1'b0;
    case (opcode)
      OpLui, OpAuipc: enc_instr = {imm[31:12], rd, opcode};
      OpJal:          enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      OpJalr, OpLoad: enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
      OpAluImm: begin
        if (is_shift) enc_instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else          enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
      end
      OpStore:  enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      OpBranch: enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      OpAluReg: enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      default:  bad_opcode = 1'b1;
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic fits_s12, fits_u12, fits_s13, fits_u13, fits_s21;

  // A signed N-bit value has all bits from N-1 upward equal to the sign.
  assign fits_s12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits_u12 = !(|imm[31:12]);
  assign fits_s13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits_u13 = !(|imm[31:13]);
  assign fits_s21 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    range_err = 1'b0;
    case (opcode)
      OpLui, OpAuipc: range_err = |imm[11:0];
      OpJal:          range_err = !fits_s21 || imm[0];
      OpJalr:         range_err = !fits_s12;
      OpLoad:         range_err = funct3[2] ? !fits_u12 : !fits_s12;
      OpAluImm:       range_err = is_shift ? (|imm[31:5]) : !fits_s12;
      OpStore:        range_err = !fits_s12;
      OpBranch:       range_err = ((funct3[2:1] == 2'b11) ? !fits_u13 : !fits_s13) || imm[0];
      default:        range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign enc_err = bad_opcode || range_err;

  // Output FIFO
  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr;
  logic              full, push, pop;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;
  assign out_instr = instr_mem[rd_ptr_q];
  assign out_addr  = addr_mem[rd_ptr_q];
  // A clear coinciding with a push labels that push with the base address.
  assign wr_addr   = addr_clr ? BASE_ADDR : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem[i] <= '0;
        addr_mem[i]  <= BASE_ADDR;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr_q] <= enc_instr;
        addr_mem[wr_ptr_q]  <= wr_addr;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (!push && pop) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= BASE_ADDR;
    end else if (push) begin
      addr_q <= wr_addr + ADDR_W'(1);
    end else if (addr_clr) begin
      addr_q <= BASE_ADDR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (push && enc_err) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=2, ADDR_W=10, BASE_ADDR=0).
module tb_instr_encoder;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic        addr_clr, err_clr, err_sticky;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam logic RangeErr = 1'b1;
`else
  localparam logic RangeErr = 1'b0;
`endif

  instr_encoder #(.DEPTH(2), .ADDR_W(10), .BASE_ADDR(10'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .addr_clr  (addr_clr),
    .err_clr   (err_clr),
    .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Push one bundle into an empty FIFO, check the head, then pop it.
  task automatic send_check(input string tag, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im, input logic aclr,
                            input logic eclr, input logic [31:0] exp_instr,
                            input logic [31:0] exp_addr);
    drive(op, d, s1, s2, f3, f7, im);
    in_valid = 1'b1; addr_clr = aclr; err_clr = eclr; out_ready = 1'b0;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; addr_clr = 1'b0; err_clr = 1'b0;
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".instr"}, out_instr, exp_instr);
    chk({tag, ".addr"}, {22'd0, out_addr}, exp_addr);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".popped"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; addr_clr = 1'b0; err_clr = 1'b0;
    drive(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.instr", out_instr, 32'd0);
    chk("rst.addr", {22'd0, out_addr}, 32'd0);
    chk("rst.err", {31'd0, err_sticky}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Encoding of each format
    send_check("addi", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 0, 0, 32'h00500093, 0);
    send_check("sw", 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 0, 0, 32'h0020A423, 1);
    send_check("beq", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFC, 0, 0,
               32'hFE000EE3, 2);
    send_check("jal", 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h800, 0, 0,
               32'h001000EF, 3);
    send_check("lui", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 0, 0,
               32'h123452B7, 4);
    send_check("sub", 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'b0100000, 32'd0, 0, 0,
               32'h402081B3, 5);
    send_check("srai", 7'b0010011, 5'd5, 5'd6, 5'd0, 3'b101, 7'b0100000, 32'd3, 0, 0,
               32'h40335293, 6);
    send_check("lw", 7'b0000011, 5'd4, 5'd2, 5'd0, 3'b010, 7'd0, 32'hFFFFFFFF, 0, 0,
               32'hFFF12203, 7);
    send_check("jalr", 7'b1100111, 5'd0, 5'd1, 5'd0, 3'b000, 7'd0, 32'd0, 0, 0,
               32'h00008067, 8);
    chk("valid_ops.err", {31'd0, err_sticky}, 32'd0);

    // Address clear alone, then together with a push
    addr_clr = 1'b1;
    @(posedge clk); #1;
    addr_clr = 1'b0;
    send_check("clr_alone", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 0, 0,
               32'h00500093, 0);
    send_check("clr_push", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1, 0,
               32'h00500093, 0);
    send_check("after_clr", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 0, 0,
               32'h00500093, 1);

    // Fill the FIFO with out_ready low; the third bundle must wait for a pop
    out_ready = 1'b0;
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2);
    @(posedge clk); #1;
    chk("full.in_ready", {31'd0, in_ready}, 32'd0);
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3);
    @(posedge clk); #1;
    chk("full.hold_instr", out_instr, 32'h00100093);
    chk("full.hold_addr", {22'd0, out_addr}, 32'd2);
    chk("full.still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("pop1.instr", out_instr, 32'h00200093);
    chk("pop1.addr", {22'd0, out_addr}, 32'd3);
    chk("pop1.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pop2.valid", {31'd0, out_valid}, 32'd1);
    chk("pop2.instr", out_instr, 32'h00300093);
    chk("pop2.addr", {22'd0, out_addr}, 32'd4);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drained.valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with the FIFO full
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd7);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("prerst.in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_check("postrst", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 0, 0,
               32'h00500093, 0);

    // Error flag behaviour
    send_check("addi2048", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 0, 0,
               32'h80000093, 1);
    chk("addi2048.err", {31'd0, err_sticky}, {31'd0, RangeErr});
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr1.err", {31'd0, err_sticky}, 32'd0);
    send_check("badop", 7'h7F, 5'd1, 5'd2, 5'd3, 3'b111, 7'h7F, 32'hDEADBEEF, 0, 0,
               32'h00000013, 2);
    chk("badop.err", {31'd0, err_sticky}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr2.err", {31'd0, err_sticky}, 32'd0);
    send_check("setwins", 7'h7F, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 0, 1,
               32'h00000013, 3);
    chk("setwins.err", {31'd0, err_sticky}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
